frog_control: RTL and testbench

FROG_CONTROL -- requirements
Module: frog_control

---
 rtl/frog_pkg.sv | 24 ++
 rtl/frog_control_button_edge.sv | 37 +++
 rtl/frog_control.sv | 137 +++++++++++++
 tb/tb_frog_control.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// frog_pkg -- shared types and constants for the frog controller.
//   state_t  : controller states (IDLE / PLAY / DEAD)
//   GRID     : playfield is GRID x GRID cells
//   START_ROW: row the frog spawns in (bottom of the field)
//   POS_W    : bit width of a row or column index
//   B_*      : bit positions of each button in the packed button vector
package frog_pkg;
  localparam int GRID      = 16;
  localparam int START_ROW = 15;
  localparam int POS_W     = 4;

  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef logic [POS_W-1:0] pos_t;
endpackage

// File: rtl/frog_control_button_edge.sv
// button_edge -- synchronizes one raw button level and emits a one-cycle
// pulse on its rising edge.
//   clock   : system clock
//   reset   : synchronous active-low reset
//   i_btn   : raw asynchronous button level
//   o_pulse : high for one cycle, the cycle after the synchronized rise
// A press first sampled at edge k produces o_pulse between edges k+1 and k+2.
module button_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);
  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [2:0] r_warm;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_warm  <= {r_warm[1:0], 1'b1};
    end
  end

  // The pipeline flops come out of reset at 0, so a button held through
  // reset release would look like a fresh rise. Pulses stay masked until
  // r_prev holds a genuine post-reset sample.
  assign o_pulse = r_sync2 & ~r_prev & r_warm[2];
endmodule

// File: rtl/frog_control.sv
// frog_control -- frog position / life-cycle controller.
//   clock, reset             : rising-edge clock, synchronous active-low reset
//   up, down, left, right    : raw asynchronous button levels
//   hazard[256]              : car occupancy, bit 16*row+col
//   game_over                : score block ends play
//   frog_row, frog_col       : current frog cell (row 0 = goal, 15 = start)
//   frog_valid               : frog is drawn
//   win, lose, in            : one-cycle event pulses to the score block
module frog_control
  import frog_pkg::*;
#(
  parameter int START_COL = 7,
  parameter int LOCKOUT   = 25_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  input  logic [255:0] hazard,
  input  logic         game_over,
  output logic [3:0]   frog_row,
  output logic [3:0]   frog_col,
  output logic         frog_valid,
  output logic         win,
  output logic         lose,
  output logic         in
);
  localparam int   CW        = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam pos_t ROW_START = pos_t'(START_ROW);
  localparam pos_t COL_START = pos_t'(START_COL);
  localparam pos_t POS_MAX   = pos_t'(GRID - 1);

  logic [3:0] w_raw;
  logic [3:0] w_btn;
  pos_t       w_row;
  pos_t       w_col;
  logic       w_hit;

  state_t        r_state;
  pos_t          r_row;
  pos_t          r_col;
  logic          r_valid;
  logic          r_win;
  logic          r_lose;
  logic          r_in;
  logic [CW-1:0] r_cnt;

  assign w_raw = {up, down, left, right};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    button_edge u_btn (
      .clock   (clock),
      .reset   (reset),
      .i_btn   (w_raw[gi]),
      .o_pulse (w_btn[gi])
    );
  end

  assign w_hit = hazard[{r_row, r_col}];

  // Candidate position for this cycle's move; first set button wins.
  always_comb begin
    w_row = r_row;
    w_col = r_col;
    if (w_btn[B_UP])
      w_row = (r_row == '0) ? r_row : r_row - pos_t'(1);
    else if (w_btn[B_DOWN])
      w_row = (r_row == POS_MAX) ? r_row : r_row + pos_t'(1);
    else if (w_btn[B_LEFT])
      w_col = (r_col == '0) ? r_col : r_col - pos_t'(1);
    else if (w_btn[B_RIGHT])
      w_col = (r_col == POS_MAX) ? r_col : r_col + pos_t'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_row   <= ROW_START;
      r_col   <= COL_START;
      r_valid <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_in    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_win  <= 1'b0;
      r_lose <= 1'b0;
      r_in   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|w_btn) begin
            r_in    <= 1'b1;
            r_row   <= ROW_START;
            r_col   <= COL_START;
            r_valid <= 1'b1;
            r_state <= PLAY;
          end
        end
        PLAY: begin
          if (game_over) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else if (w_hit) begin
            // Collision discards any move made in the same cycle.
            r_lose  <= 1'b1;
            r_valid <= 1'b0;
            r_cnt   <= CW'(LOCKOUT - 1);
            r_state <= DEAD;
          end else if (|w_btn) begin
            if (w_row == '0) begin
              r_win <= 1'b1;
              r_row <= ROW_START;
              r_col <= COL_START;
            end else begin
              r_row <= w_row;
              r_col <= w_col;
            end
          end
        end
        DEAD: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign frog_row   = r_row;
  assign frog_col   = r_col;
  assign frog_valid = r_valid;
  assign win        = r_win;
  assign lose       = r_lose;
  assign in         = r_in;
endmodule

// File: tb/tb_frog_control.sv
module tb_frog_control;
  localparam int LOCK = 4;
  localparam int SC   = 7;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [255:0] hazard = '0;
  logic         game_over = 1'b0;
  logic [3:0]   frog_row, frog_col;
  logic         frog_valid, win, lose, in;

  frog_control #(.START_COL(SC), .LOCKOUT(LOCK)) dut (
    .clock(clock), .reset(reset), .up(up), .down(down), .left(left),
    .right(right), .hazard(hazard), .game_over(game_over),
    .frog_row(frog_row), .frog_col(frog_col), .frog_valid(frog_valid),
    .win(win), .lose(lose), .in(in)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int n_in = 0, n_win = 0, n_lose = 0;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-edge history of sampled buttons/reset; a move event
  // at edge t is a button low at t-3 and high at t-2, with reset released
  // over the whole window t-3..t.
  bit [3:0] hb [4];
  bit       hr [4];
  bit [3:0] m_ev;
  int m_mode = 0;            // 0 idle, 1 play, 2 dead
  int m_row = 15, m_col = SC, m_valid = 0;
  int m_win = 0, m_lose = 0, m_in = 0, m_left = 0;
  int nr, nc;

  always @(posedge clock) begin
    for (int i = 3; i > 0; i--) begin hb[i] = hb[i-1]; hr[i] = hr[i-1]; end
    hb[0] = {up, down, left, right};
    hr[0] = reset;
    m_ev = (hr[0] && hr[1] && hr[2] && hr[3]) ? (hb[2] & ~hb[3]) : 4'b0;
    m_win = 0; m_lose = 0; m_in = 0;
    if (!reset) begin
      m_mode = 0; m_row = 15; m_col = SC; m_valid = 0; m_left = 0;
    end else if (m_mode == 0) begin
      if (m_ev != 0) begin
        m_in = 1; m_row = 15; m_col = SC; m_valid = 1; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (game_over) begin
        m_mode = 0; m_valid = 0;
      end else if (hazard[m_row*16 + m_col]) begin
        m_lose = 1; m_valid = 0; m_left = LOCK; m_mode = 2;
      end else if (m_ev != 0) begin
        nr = m_row; nc = m_col;
        if (m_ev[3])      nr = (nr > 0)  ? nr - 1 : 0;
        else if (m_ev[2]) nr = (nr < 15) ? nr + 1 : 15;
        else if (m_ev[1]) nc = (nc > 0)  ? nc - 1 : 0;
        else              nc = (nc < 15) ? nc + 1 : 15;
        if (nr == 0) begin m_win = 1; m_row = 15; m_col = SC; end
        else begin m_row = nr; m_col = nc; end
      end
    end else begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("row",   frog_row,   m_row);
      chk("col",   frog_col,   m_col);
      chk("valid", frog_valid, m_valid);
      chk("win",   win,        m_win);
      chk("lose",  lose,       m_lose);
      chk("in",    in,         m_in);
      if (win)  n_win++;
      if (lose) n_lose++;
      if (in)   n_in++;
    end
  end

  task automatic press(input bit [3:0] m);
    @(negedge clock); {up, down, left, right} = m;
    repeat (2) @(negedge clock); {up, down, left, right} = 4'b0;
    repeat (3) @(negedge clock);
  endtask

  int c0, c1, c2;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    started = 1;
    chk("rst_row", frog_row, 15);
    chk("rst_col", frog_col, SC);
    chk("rst_valid", frog_valid, 0);
    chk("rst_pulses", {win, lose, in}, 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // start from IDLE
    c0 = n_in; press(4'b1000);
    chk("idle_in_once", n_in - c0, 1);
    chk("idle_pos", {frog_row, frog_col}, {4'd15, 4'd7});
    chk("idle_valid", frog_valid, 1);

    // climb to the goal
    for (int i = 1; i <= 14; i++) begin
      press(4'b1000);
      chk("climb_row", frog_row, 15 - i);
    end
    c0 = n_win; press(4'b1000);
    chk("goal_win_once", n_win - c0, 1);
    chk("goal_pos", {frog_row, frog_col}, {4'd15, 4'd7});

    // held left moves once; clamping at col 0 and row 15
    @(negedge clock); left = 1'b1;
    repeat (10) @(negedge clock); left = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_left", frog_col, 6);
    for (int i = 0; i < 6; i++) press(4'b0010);
    chk("left_to_0", frog_col, 0);
    press(4'b0010);
    chk("left_clamp", frog_col, 0);
    press(4'b0100);
    chk("down_clamp", frog_row, 15);

    // collision, lockout, then re-entry
    for (int i = 0; i < 7; i++) press(4'b0001);
    chk("right_to_7", frog_col, 7);
    c0 = n_lose; c1 = n_in;
    @(negedge clock); hazard[247] = 1'b1; up = 1'b1;
    @(negedge clock); hazard = '0;
    @(negedge clock); up = 1'b0;
    repeat (3) @(negedge clock);
    chk("hit_lose_once", n_lose - c0, 1);
    chk("hit_valid", frog_valid, 0);
    chk("dead_ignores", n_in - c1, 0);
    repeat (4) @(negedge clock);
    c1 = n_in; press(4'b1000);
    chk("after_dead_in", n_in - c1, 1);

    // up+right together: up only
    press(4'b1001);
    chk("prio_pos", {frog_row, frog_col}, {4'd14, 4'd7});

    // up move and hazard hit in the same cycle
    c0 = n_lose; c1 = n_win;
    @(negedge clock); up = 1'b1;
    @(negedge clock);
    @(negedge clock); up = 1'b0; hazard[14*16 + 7] = 1'b1;
    @(negedge clock); hazard = '0;
    repeat (2) @(negedge clock);
    chk("hitmove_lose", n_lose - c0, 1);
    chk("hitmove_win", n_win - c1, 0);
    chk("hitmove_pos", {frog_row, frog_col}, {4'd14, 4'd7});
    repeat (6) @(negedge clock);
    press(4'b1000);

    // game_over from PLAY
    c0 = n_in; c1 = n_win; c2 = n_lose;
    @(negedge clock); game_over = 1'b1;
    @(negedge clock); game_over = 1'b0;
    @(negedge clock);
    chk("go_valid", frog_valid, 0);
    chk("go_no_pulse", (n_in - c0) + (n_win - c1) + (n_lose - c2), 0);
    c0 = n_in; press(4'b0100);
    chk("go_idle_in", n_in - c0, 1);

    // reset while DEAD
    @(negedge clock); hazard[247] = 1'b1;
    @(negedge clock); hazard = '0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    chk("dead_rst_pos", {frog_row, frog_col}, {4'd15, 4'd7});
    chk("dead_rst_valid", frog_valid, 0);
    chk("dead_rst_pulses", {win, lose, in}, 0);
    repeat (4) @(negedge clock);
    c0 = n_in; press(4'b0010);
    chk("dead_rst_in", n_in - c0, 1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) up    = ~up;
      if ($urandom_range(0, 5) == 0) down  = ~down;
      if ($urandom_range(0, 5) == 0) left  = ~left;
      if ($urandom_range(0, 5) == 0) right = ~right;
      hazard = '0;
      if ($urandom_range(0, 11) == 0) hazard[$urandom_range(0, 255)] = 1'b1;
      if ($urandom_range(0, 79) == 0) hazard[m_row*16 + m_col] = 1'b1;
      game_over = ($urandom_range(0, 60) == 0);
      reset = !($urandom_range(0, 300) == 0);
    end
    {up, down, left, right} = 4'b0;
    hazard = '0; game_over = 1'b0; reset = 1'b1;
    repeat (5) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
